next_pc_unit: RTL and testbench
===============================

# next_pc_unit

Program-counter stage of the single-cycle CPU. Holds the architectural PC and NZCV flags register, evaluates branch conditions, and loads the next PC each cycle: sequential PC+4, PC-relative target (B, B.cond, CBZ), or register target (BR). It sits directly downstream of the datapath's 2:1 select muxes, which steer the ALU zero flag and register operand into it. It feeds instruction memory and the BL link-register write path.

## Interface
Parameters:
- ADDR_W, 64, PC and target width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- stall  in  1  1 = hold PC and flags this cycle
- br_reg  in  1  BR: next PC = reg_target
- uncond_br  in  1  B/BL: unconditional PC-relative
- cond_br  in  1  B.cond: PC-relative if cond holds on stored flags
- cbz  in  1  CBZ: PC-relative if zero_in = 1
- cond  in  4  condition code for B.cond
- br_offset  in  ADDR_W  signed word offset, already sign-extended
- reg_target  in  ADDR_W  BR target from register read port
- zero_in  in  1  ALU zero for CBZ operand
- set_flags  in  1  capture alu_flags at clock edge
- alu_flags  in  4  {N,Z,C,V} from ALU
- pc  out  ADDR_W  current PC, registered
- pc_plus4  out  ADDR_W  pc + 4, combinational (BL link value)
- flags  out  4  stored {N,Z,C,V}, registered
- taken  out  1  combinational: a non-sequential next PC is selected this cycle
- misalign  out  1  sticky: a BR target had reg_target[1:0] != 0

## Operation
- Reset (reset = 0): pc = RESET_PC, flags = 0000, misalign = 0; held while reset low; release takes effect at next rising edge.
- Selection priority when multiple controls assert: br_reg > uncond_br > cond_br > cbz > sequential.
- rel_target = pc + (br_offset << 2), truncated to ADDR_W (wrap-around, no overflow detection).
- Sequential next PC = pc + 4, wraps from 2^ADDR_W - 4 to 0.
- B.cond evaluates cond on the stored flags register, not alu_flags of the same cycle.
- Codes: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !(C&!Z); 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V)); 1110/1111 always.
- BR: next PC = {reg_target[ADDR_W-1:2], 2'b00}; if reg_target[1:0] != 0, misalign sets to 1 and stays until reset.
- taken = br_reg | uncond_br | (cond_br & cond_true) | (cbz & zero_in); it is unaffected by stall.
- stall = 1: pc, flags, and misalign hold; set_flags is ignored.

## Timing
- Single-cycle: next PC and flags commit at the same rising edge; pc output changes only on edges or on asynchronous reset.
- set_flags and B.cond in the same cycle: branch uses the old flags, and new flags are written at the edge.
- Reset asserted mid-cycle: outputs return to reset values without waiting for clk.
- pc_plus4 and taken are valid combinationally within the cycle and have no registered latency.

## Structure
- Shared package cpu_pkg: cond_e enum (the 16 codes above), flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, cond_eval: combinational {cond, flags} -> cond_true, reusable by later pipelined variants.
- Top holds the PC register, flags register, misalign flop, adders, and priority select.

## Test plan
- Reset: assert reset = 0 mid-cycle with pc = 0x40 -> pc = 0 and flags = 0 immediately; release with no controls -> pc = 4, then 8.
- B: pc = 0x100, uncond_br = 1, br_offset = -2 -> taken = 1, next pc = 0xF8. Repeat with pc = 0, br_offset = -1 -> pc = 0xFFFF_FFFF_FFFF_FFFC.
- B.cond: set_flags with alu_flags = 1001 (N,V), then cond_br with cond = GE -> taken; cond = LT -> not taken, pc += 4. Same-cycle set_flags = 0100 plus cond = EQ with stored Z = 0 -> not taken, and flags = 0100 afterwards.
- CBZ: zero_in = 1, br_offset = 3, pc = 0x20 -> pc = 0x2C; zero_in = 0 -> pc = 0x24.
- BR: reg_target = 0x203 -> pc = 0x200, misalign = 1; a later aligned BR leaves misalign = 1 until reset.
- Stall and priority: stall = 1 with uncond_br and set_flags asserted -> pc and flags unchanged, taken = 1. br_reg and uncond_br together -> reg_target wins.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes and NZCV flag bit positions.
// Pure types and constants, no logic.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: {cond, NZCV} -> cond_true, purely combinational.
// No state and no handshake; usable unchanged by pipelined PC stages.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b1;
    case (cond_e'(cond))
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_HS: cond_true = c;
      COND_LO: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c && !z;
      COND_LS: cond_true = !(c && !z);
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z && (n == v);
      COND_LE: cond_true = !(!z && (n == v));
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: rtl/next_pc_unit.sv
// PC stage: holds PC, NZCV and sticky misalign; next PC commits each edge, zero latency.
// stall holds all state (set_flags ignored) while taken/pc_plus4 stay live.
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_reg,
  input  logic              uncond_br,
  input  logic              cond_br,
  input  logic              cbz,
  input  logic [3:0]        cond,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              zero_in,
  input  logic              set_flags,
  input  logic [3:0]        alu_flags,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [3:0]        flags,
  output logic              taken,
  output logic              misalign
);

  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] rel_target, next_pc;
  logic [3:0]        flags_d, flags_q;
  logic              misalign_d, misalign_q;
  logic              cond_true;

  // B.cond looks at the stored flags, never at this cycle's ALU flags.
  cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign rel_target = pc_q + (br_offset << 2);

  always_comb begin
    taken   = 1'b1;
    next_pc = pc_plus4;
    if (br_reg) begin
      next_pc = {reg_target[ADDR_W-1:2], 2'b00};
    end else if (uncond_br) begin
      next_pc = rel_target;
    end else if (cond_br && cond_true) begin
      next_pc = rel_target;
    end else if (cbz && zero_in) begin
      next_pc = rel_target;
    end else begin
      taken = 1'b0;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    flags_d    = flags_q;
    misalign_d = misalign_q;
    if (!stall) begin
      pc_d       = next_pc;
      misalign_d = misalign_q || (br_reg && (reg_target[1:0] != 2'b00));
      if (set_flags) begin
        flags_d = alu_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      flags_q    <= 4'b0000;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      flags_q    <= flags_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign flags    = flags_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus randomized traffic
// compared against an arithmetic model of the architectural PC/flags rules.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_reg, uncond_br, cond_br, cbz, zero_in, set_flags;
  logic [3:0]  cond, alu_flags;
  logic [63:0] br_offset, reg_target;
  logic [63:0] pc, pc_plus4;
  logic [3:0]  flags;
  logic        taken, misalign;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc;
  logic [3:0]  m_fl;
  logic        m_mis;

  next_pc_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_reg(br_reg), .uncond_br(uncond_br),
    .cond_br(cond_br), .cbz(cbz), .cond(cond), .br_offset(br_offset),
    .reg_target(reg_target), .zero_in(zero_in), .set_flags(set_flags),
    .alu_flags(alu_flags), .pc(pc), .pc_plus4(pc_plus4), .flags(flags),
    .taken(taken), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Conditions pair up: odd codes invert the even base test, except 111x (always).
  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cc[0] && cc[3:1] != 3'd7) ? ~base : base;
  endfunction

  function automatic logic exp_taken();
    return br_reg || uncond_br || (cond_br && cond_holds(cond, m_fl)) || (cbz && zero_in);
  endfunction

  function automatic logic [63:0] exp_next();
    if (br_reg) return reg_target & ~64'd3;
    if (exp_taken()) return m_pc + br_offset * 4;
    return m_pc + 64'd4;
  endfunction

  task automatic clear_inputs();
    stall = 0; br_reg = 0; uncond_br = 0; cond_br = 0; cbz = 0; zero_in = 0;
    set_flags = 0; cond = 4'h0; alu_flags = 4'h0; br_offset = '0; reg_target = '0;
  endtask

  // Advance one edge and the model with it; inputs are stable across the edge.
  task automatic tick();
    logic [63:0] nxt;
    nxt = exp_next();
    @(posedge clk);
    if (reset && !stall) begin
      m_mis = m_mis | (br_reg & (reg_target[1:0] != 2'b00));
      m_pc  = nxt;
      if (set_flags) m_fl = alu_flags;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 0; m_pc = '0; m_fl = '0; m_mis = 0;
    #3;
    reset = 1;
    clear_inputs();
  endtask

  task automatic jump_to(input logic [63:0] a);
    clear_inputs(); br_reg = 1; reg_target = a;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    jump_to(64'h40);
    set_flags = 1; alu_flags = 4'b1111; stall = 1;
    tick();
    clear_inputs();
    checks++; if (pc !== 64'h40) begin errors++; $display("FAIL rst_pre_pc got %h want %h", pc, 64'h40); end
    #1 reset = 0; m_pc = '0; m_fl = '0; m_mis = 0;
    #1;
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL rst_async_pc got %h want 0", pc); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rst_async_flags got %h want 0", flags); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_async_mis got %b want 0", misalign); end
    #5 reset = 1;
    tick();
    checks++; if (pc !== 64'h4) begin errors++; $display("FAIL rst_rel_pc1 got %h want 4", pc); end
    tick();
    checks++; if (pc !== 64'h8) begin errors++; $display("FAIL rst_rel_pc2 got %h want 8", pc); end
  endtask

  task automatic test_branch();
    jump_to(64'h100);
    uncond_br = 1; br_offset = -64'sd2; #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL b_taken got %b want 1", taken); end
    tick();
    checks++; if (pc !== 64'hF8) begin errors++; $display("FAIL b_neg2 pc got %h want %h", pc, 64'hF8); end
    jump_to(64'h0);
    uncond_br = 1; br_offset = -64'sd1;
    tick();
    checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL b_wrap pc got %h", pc); end
    clear_inputs(); #1;
    checks++; if (pc_plus4 !== 64'h0) begin errors++; $display("FAIL plus4_wrap got %h want 0", pc_plus4); end
    tick();
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL seq_wrap pc got %h want 0", pc); end
  endtask

  task automatic test_bcond();
    jump_to(64'h1000);
    set_flags = 1; alu_flags = 4'b1001;
    tick();
    clear_inputs();
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL bc_flags got %b want 1001", flags); end
    cond_br = 1; cond = 4'b1010; br_offset = 64'd5; #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bc_ge_taken got %b want 1", taken); end
    tick();
    checks++; if (pc !== 64'h1018) begin errors++; $display("FAIL bc_ge_pc got %h want 1018", pc); end
    cond = 4'b1011; #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bc_lt_taken got %b want 0", taken); end
    tick();
    checks++; if (pc !== 64'h101C) begin errors++; $display("FAIL bc_lt_pc got %h want 101c", pc); end
    cond = 4'b0000; set_flags = 1; alu_flags = 4'b0100; #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bc_eq_old_taken got %b want 0", taken); end
    tick();
    clear_inputs();
    checks++; if (pc !== 64'h1020) begin errors++; $display("FAIL bc_eq_pc got %h want 1020", pc); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL bc_eq_flags got %b want 0100", flags); end
  endtask

  task automatic test_cbz();
    jump_to(64'h20);
    cbz = 1; zero_in = 1; br_offset = 64'd3;
    tick();
    checks++; if (pc !== 64'h2C) begin errors++; $display("FAIL cbz_taken pc got %h want 2c", pc); end
    jump_to(64'h20);
    cbz = 1; zero_in = 0; br_offset = 64'd3; #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL cbz_nt taken got %b want 0", taken); end
    tick();
    checks++; if (pc !== 64'h24) begin errors++; $display("FAIL cbz_nt pc got %h want 24", pc); end
  endtask

  task automatic test_br();
    apply_reset();
    jump_to(64'h203);
    checks++; if (pc !== 64'h200) begin errors++; $display("FAIL br_mis pc got %h want 200", pc); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL br_mis flag got %b want 1", misalign); end
    jump_to(64'h400);
    checks++; if (pc !== 64'h400) begin errors++; $display("FAIL br_al pc got %h want 400", pc); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL br_sticky got %b want 1", misalign); end
    apply_reset();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL br_clr got %b want 0", misalign); end
  endtask

  task automatic test_stall_priority();
    jump_to(64'h500);
    stall = 1; uncond_br = 1; br_offset = 64'd8; set_flags = 1; alu_flags = 4'b1111; #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL stall_taken got %b want 1", taken); end
    tick();
    checks++; if (pc !== 64'h500) begin errors++; $display("FAIL stall_pc got %h want 500", pc); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL stall_flags got %b want 0000", flags); end
    clear_inputs(); stall = 1; br_reg = 1; reg_target = 64'h701;
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL stall_mis got %b want 0", misalign); end
    clear_inputs(); br_reg = 1; uncond_br = 1; reg_target = 64'h800; br_offset = 64'd4;
    tick();
    checks++; if (pc !== 64'h800) begin errors++; $display("FAIL prio_br pc got %h want 800", pc); end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom_range(3) == 0);
      br_reg    = ($urandom_range(5) == 0);
      uncond_br = ($urandom_range(4) == 0);
      cond_br   = ($urandom_range(2) == 0);
      cbz       = ($urandom_range(3) == 0);
      zero_in   = $urandom_range(1);
      set_flags = $urandom_range(1);
      cond      = 4'($urandom_range(15));
      alu_flags = 4'($urandom_range(15));
      br_offset = ($urandom_range(1) == 0) ? {$urandom, $urandom} : 64'($signed(8'($urandom)));
      reg_target = ($urandom_range(1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(4095));
      #1;
      checks++; if (taken !== exp_taken()) begin errors++; $display("FAIL rnd_taken i=%0d got %b want %b", i, taken, exp_taken()); end
      checks++; if (pc_plus4 !== m_pc + 64'd4) begin errors++; $display("FAIL rnd_plus4 i=%0d got %h want %h", i, pc_plus4, m_pc + 64'd4); end
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc i=%0d got %h want %h", i, pc, m_pc); end
      checks++; if (flags !== m_fl) begin errors++; $display("FAIL rnd_flags i=%0d got %b want %b", i, flags, m_fl); end
      checks++; if (misalign !== m_mis) begin errors++; $display("FAIL rnd_mis i=%0d got %b want %b", i, misalign, m_mis); end
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset = 0; m_pc = '0; m_fl = '0; m_mis = 0;
    #12;
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %h want 0", flags); end
    reset = 1;
    #1;
    test_reset();
    test_branch();
    test_bcond();
    test_cbz();
    test_br();
    test_stall_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
